// File: rtl/key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : p_key2 / key_schedule_seq
// Description : Sequential DES key-schedule engine. Loads a 56-bit post-PC-1
//               key and emits ROUNDS 48-bit subkeys through a valid/ready
//               handshake, in encrypt (K1..Kn) or decrypt (Kn..K1) order.
//               p_key2 is the PC-2 compression (56 -> 48) used on {C,D}.
// Revision    : 1.0 - initial sequential engine
// ============================================================================

module p_key2 (
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    // PC-2 taps, 1-based from the MSB of {C,D}; entry i drives output bit i
    // counted 1-based from the MSB of the subkey.
    localparam int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Pure wiring: each subkey bit is a fixed tap into the key state.
    for (genvar i = 0; i < 48; i++) begin : g_pc2_bit
        assign o_subkey[47-i] = i_cd[56-c_pc2[i]];
    end

endmodule

module key_schedule_seq #(
    parameter int          ROUNDS    = 16,
    parameter logic [15:0] SHIFT_MAP = 16'h8103,
    parameter int          RND_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [55:0]      key_in,
    input  logic             abort,
    output logic [47:0]      subkey,
    output logic             subkey_valid,
    input  logic             subkey_ready,
    output logic [RND_W-1:0] round_idx,
    output logic [55:0]      key_state,
    output logic             busy,
    output logic             done
);

    localparam logic [RND_W-1:0] c_last_round  = RND_W'(ROUNDS);
    localparam logic [RND_W-1:0] c_first_round = RND_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // True when round r (1-based) rotates by one position, otherwise by two.
    function automatic logic shift_is_one(input int r);
        logic res;
        res = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i + 1 == r) res = SHIFT_MAP[i];
        end
        return res;
    endfunction

    // Circular left rotate of one 28-bit half by 1 or 2.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_one);
        return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    // Circular right rotate of one 28-bit half by 1 or 2.
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_one);
        return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t           r_state;
    logic [27:0]      r_c;
    logic [27:0]      r_d;
    logic             r_mode;
    logic [RND_W-1:0] r_round;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_step_one;
    logic [27:0]      w_c_next;
    logic [27:0]      w_d_next;
    logic [27:0]      w_c_load;
    logic [27:0]      w_d_load;

    // Next {C,D} for the following round and for a fresh load from key_in.
    // Decrypt walks the encrypt schedule backwards, so it undoes the shift of
    // the round it is leaving, starting from the unrotated key (= last key).
    always_comb begin
        w_step_one = 1'b0;
        w_c_next   = r_c;
        w_d_next   = r_d;
        w_c_load   = key_in[55:28];
        w_d_load   = key_in[27:0];
        if (r_mode) begin
            w_step_one = shift_is_one(ROUNDS + 1 - int'(r_round));
            w_c_next   = rotr28(r_c, w_step_one);
            w_d_next   = rotr28(r_d, w_step_one);
        end else begin
            w_step_one = shift_is_one(int'(r_round) + 1);
            w_c_next   = rotl28(r_c, w_step_one);
            w_d_next   = rotl28(r_d, w_step_one);
        end
        if (!mode) begin
            w_c_load = rotl28(key_in[55:28], SHIFT_MAP[0]);
            w_d_load = rotl28(key_in[27:0], SHIFT_MAP[0]);
        end
    end

    // Run control: load on start, advance on each handshake, stop on the
    // last accepted subkey or on abort. Abort outranks a same-edge handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_mode  <= 1'b0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_mode  <= mode;
                        r_c     <= w_c_load;
                        r_d     <= w_d_load;
                        r_round <= c_first_round;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (subkey_ready) begin
                        if (r_round == c_last_round) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_round <= r_round + c_first_round;
                            r_c     <= w_c_next;
                            r_d     <= w_d_next;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Subkey is compressed straight from the C/D register, no extra stage.
    p_key2 u_p_key2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

    assign key_state    = {r_c, r_d};
    assign round_idx    = r_round;
    assign subkey_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_schedule_seq
// Description : Self-checking bench for key_schedule_seq (default 16-round
//               instance plus a 4-round instance) against a cumulative-offset
//               reference model of the DES key schedule.
// Revision    : 1.0 - initial bench
// ============================================================================

module tb_key_schedule_seq;

    localparam logic [55:0] c_key_ref = 56'hF0CCAAF556678F;
    localparam logic [47:0] c_k1      = 48'h1B02EFFC7072;
    localparam logic [47:0] c_k16     = 48'hCB3D8B0E17F5;

    localparam int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode, abort, ready;
    logic [55:0] key_in;
    logic [47:0] subkey;
    logic        valid, busy, done;
    logic [4:0]  round_idx;
    logic [55:0] key_state;

    logic        start4, mode4, abort4, ready4;
    logic [55:0] key4;
    logic [47:0] subkey4;
    logic        valid4, busy4, done4;
    logic [4:0]  round4;
    logic [55:0] ks4;

    int vecs = 0;
    int errs = 0;

    logic [47:0] exp_sk  [16];
    logic [55:0] exp_ks  [16];
    logic [47:0] enc_seq [16];

    key_schedule_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
        .abort(abort), .subkey(subkey), .subkey_valid(valid),
        .subkey_ready(ready), .round_idx(round_idx), .key_state(key_state),
        .busy(busy), .done(done)
    );

    key_schedule_seq #(.ROUNDS(4), .SHIFT_MAP(16'h0003), .RND_W(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .key_in(key4),
        .abort(abort4), .subkey(subkey4), .subkey_valid(valid4),
        .subkey_ready(ready4), .round_idx(round4), .key_state(ks4),
        .busy(busy4), .done(done4)
    );

    // ---------------- reference model ----------------
    function automatic logic [47:0] m_pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-c_pc2[i]];
        return o;
    endfunction

    function automatic logic [55:0] m_rot(input logic [55:0] k, input int amt);
        logic [27:0] c, d;
        c = k[55:28];
        d = k[27:0];
        for (int i = 0; i < amt; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    function automatic int m_s(input logic [15:0] map, input int r);
        return map[r-1] ? 1 : 2;
    endfunction

    // Subkey k is the key rotated left by a cumulative offset: encrypt sums
    // s(1..k); decrypt starts at 0 and subtracts s(R), s(R-1), ...
    task automatic build(input logic [55:0] key, input bit md, input int rounds,
                         input logic [15:0] map);
        int off;
        off = 0;
        for (int k = 1; k <= rounds; k++) begin
            if (!md) off = off + m_s(map, k);
            else if (k > 1) off = off - m_s(map, rounds + 2 - k);
            exp_ks[k-1] = m_rot(key, ((off % 28) + 28) % 28);
            exp_sk[k-1] = m_pc2(exp_ks[k-1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; mode = 1'b0; key_in = c_key_ref; abort = 1'b0; ready = 1'b1;
        start4 = 1'b1; mode4 = 1'b0; key4 = c_key_ref; abort4 = 1'b0; ready4 = 1'b1;
        tick(); tick();
        vecs++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL reset_flags: got v%b b%b d%b expected 000", valid, busy, done); end
        vecs++; if (round_idx !== 5'd0) begin
            errs++; $display("FAIL reset_round: got %0d expected 0", round_idx); end
        vecs++; if (key_state !== 56'd0 || subkey !== 48'd0) begin
            errs++; $display("FAIL reset_key: got ks %h sk %h expected 0", key_state, subkey); end
        vecs++; if (valid4 !== 1'b0 || ks4 !== 56'd0) begin
            errs++; $display("FAIL reset_dut4: got v%b ks %h expected 0", valid4, ks4); end
        start = 1'b0; start4 = 1'b0; rst_n = 1'b1;
        tick();
        vecs++; if (valid !== 1'b0) begin
            errs++; $display("FAIL reset_idle: got valid %b expected 0", valid); end
    endtask

    task automatic test_encrypt();
        build(c_key_ref, 1'b0, 16, 16'h8103);
        for (int k = 0; k < 16; k++) enc_seq[k] = exp_sk[k];
        mode = 1'b0; key_in = c_key_ref; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vecs++; if (valid !== 1'b1 || round_idx !== 5'(k + 1) || subkey !== exp_sk[k]) begin
                errs++; $display("FAIL enc_step%0d: got v%b r%0d %h expected v1 r%0d %h",
                                 k, valid, round_idx, subkey, k + 1, exp_sk[k]); end
            if (k == 0) begin
                vecs++; if (subkey !== c_k1) begin
                    errs++; $display("FAIL enc_K1: got %h expected %h", subkey, c_k1); end
            end
            if (k == 15) begin
                vecs++; if (subkey !== c_k16) begin
                    errs++; $display("FAIL enc_K16: got %h expected %h", subkey, c_k16); end
            end
            tick();
        end
        vecs++; if (done !== 1'b1 || valid !== 1'b0 || key_state !== c_key_ref) begin
            errs++; $display("FAIL enc_done: got d%b v%b ks %h expected d1 v0 ks %h",
                             done, valid, key_state, c_key_ref); end
        ready = 1'b0;
        tick();
        vecs++; if (done !== 1'b0) begin
            errs++; $display("FAIL enc_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_decrypt();
        mode = 1'b1; key_in = c_key_ref; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vecs++; if (valid !== 1'b1 || subkey !== enc_seq[15-k]) begin
                errs++; $display("FAIL dec_step%0d: got v%b %h expected v1 %h",
                                 k, valid, subkey, enc_seq[15-k]); end
            if (k == 0) begin
                vecs++; if (subkey !== c_k16) begin
                    errs++; $display("FAIL dec_first: got %h expected %h", subkey, c_k16); end
            end
            if (k == 15) begin
                vecs++; if (subkey !== c_k1) begin
                    errs++; $display("FAIL dec_last: got %h expected %h", subkey, c_k1); end
            end
            tick();
        end
        vecs++; if (done !== 1'b1) begin
            errs++; $display("FAIL dec_done: got %b expected 1", done); end
        ready = 1'b0;
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random ready.
    task automatic run_stream(input logic [55:0] key, input bit md, input int rmode);
        int hs, cyc, dones;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        build(key, md, 16, 16'h8103);
        mode = md; key_in = key; start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        hs = 0; cyc = 0; dones = 0;
        while (hs < 16 && cyc < 200) begin
            vecs++; if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || round_idx !== 5'(hs + 1)
                        || subkey !== exp_sk[hs] || key_state !== exp_ks[hs]) begin
                errs++; $display("FAIL stream_m%0d_c%0d: got v%b b%b d%b r%0d %h expected v1 b1 d0 r%0d %h",
                                 rmode, cyc, valid, busy, done, round_idx, subkey, hs + 1, exp_sk[hs]); end
            ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (ready) hs++;
        end
        vecs++; if (hs != 16) begin
            errs++; $display("FAIL stream_timeout: got %0d handshakes expected 16", hs); end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dones++;
            vecs++; if (valid !== 1'b0) begin
                errs++; $display("FAIL stream_tail%0d: got valid %b expected 0", i, valid); end
            ready = 1'b0;
            tick();
        end
        vecs++; if (dones != 1) begin
            errs++; $display("FAIL stream_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_backpressure();
        run_stream(c_key_ref, 1'b0, 1);
        run_stream(c_key_ref, 1'b1, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            run_stream({24'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), 2);
    endtask

    task automatic test_abort();
        int k;
        mode = 1'b0; key_in = c_key_ref; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (round_idx !== 5'd5 && k < 20) begin tick(); k++; end
        vecs++; if (round_idx !== 5'd5) begin
            errs++; $display("FAIL abort_reach: got r%0d expected 5", round_idx); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vecs++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL abort_stop: got v%b b%b d%b expected 000", valid, busy, done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (done !== 1'b0 || valid !== 1'b0) begin
                errs++; $display("FAIL abort_quiet%0d: got d%b v%b expected 00", i, done, valid); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vecs++; if (valid !== 1'b1 || round_idx !== 5'd1 || subkey !== c_k1) begin
            errs++; $display("FAIL abort_restart: got v%b r%0d %h expected v1 r1 %h",
                             valid, round_idx, subkey, c_k1); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int k;
        mode = 1'b0; key_in = c_key_ref; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (round_idx !== 5'd9 && k < 20) begin tick(); k++; end
        vecs++; if (round_idx !== 5'd9) begin
            errs++; $display("FAIL rstmid_reach: got r%0d expected 9", round_idx); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vecs++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 5'd0
                    || key_state !== 56'd0 || subkey !== 48'd0) begin
            errs++; $display("FAIL rstmid_zero: got v%b b%b d%b r%0d ks %h sk %h expected all 0",
                             valid, busy, done, round_idx, key_state, subkey); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (valid !== 1'b0) begin
                errs++; $display("FAIL rstmid_idle%0d: got valid %b expected 0", i, valid); end
        end
        ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [55:0] key;
        key = {24'($urandom), 32'($urandom)};
        build(key, 1'b0, 16, 16'h8103);
        mode = 1'b0; key_in = key; start = 1'b1; ready = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            vecs++; if (round_idx !== 5'(k + 1) || subkey !== exp_sk[k]) begin
                errs++; $display("FAIL busy_start%0d: got r%0d %h expected r%0d %h",
                                 k, round_idx, subkey, k + 1, exp_sk[k]); end
            start = (k == 3);
            mode  = (k == 3);
            key_in = ~key;
            tick();
        end
        start = 1'b0;
        vecs++; if (done !== 1'b1) begin
            errs++; $display("FAIL busy_done: got %b expected 1", done); end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        vecs++; if (valid !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL start_abort: got v%b b%b expected 00", valid, busy); end
        tick();
        vecs++; if (valid !== 1'b0) begin
            errs++; $display("FAIL start_abort_late: got v%b expected 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_rounds4();
        int enc_off [4] = '{1, 2, 4, 6};
        logic [55:0] key;
        logic [55:0] want;
        for (int md = 0; md < 2; md++) begin
            key = {24'($urandom), 32'($urandom)};
            build(key, md[0], 4, 16'h0003);
            mode4 = md[0]; key4 = key; start4 = 1'b1; ready4 = 1'b1;
            tick();
            start4 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                want = md[0] ? exp_ks[k] : m_rot(key, enc_off[k]);
                vecs++; if (valid4 !== 1'b1 || round4 !== 5'(k + 1) || ks4 !== want
                            || subkey4 !== m_pc2(want)) begin
                    errs++; $display("FAIL r4_m%0d_k%0d: got v%b r%0d ks %h expected v1 r%0d ks %h",
                                     md, k, valid4, round4, ks4, k + 1, want); end
                tick();
            end
            vecs++; if (done4 !== 1'b1 || valid4 !== 1'b0) begin
                errs++; $display("FAIL r4_done_m%0d: got d%b v%b expected d1 v0", md, done4, valid4); end
            tick();
            vecs++; if (done4 !== 1'b0) begin
                errs++; $display("FAIL r4_pulse_m%0d: got %b expected 0", md, done4); end
        end
        ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_abort();
        test_reset_midrun();
        test_start_ignored();
        test_random();
        test_rounds4();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
